// File: rtl/led_display_arbiter_if.sv
// Request/grant bundle between the LED requesters and the display arbiter.
// Requester i owns req[i] and pattern_in[8*i+7:8*i].
interface led_display_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] pattern_in;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;

    modport master (
        output req,
        output pattern_in,
        input  grant,
        input  busy
    );

    modport slave (
        input  req,
        input  pattern_in,
        output grant,
        output busy
    );
endinterface

// File: rtl/led_display_arbiter.sv
// Round-robin owner of the 8-LED bank with a minimum dwell measured in prescaled
// ticks; a rotating idle pattern is shown while nobody requests.
module led_display_arbiter #(
    parameter int         NUM_REQ      = 4,
    parameter int         TICK_PERIOD  = 12_500_000,
    parameter int         DWELL_TICKS  = 4,
    parameter logic [7:0] IDLE_PATTERN = 8'h01
) (
    input  logic                  clk_50mhz,
    input  logic                  reset,
    led_display_arbiter_if.slave  bus,
    output logic                  tick,
    output logic [7:0]            leds
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PRE_W = $clog2(TICK_PERIOD);
    localparam int DWL_W = $clog2(DWELL_TICKS + 1);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_PERIOD - 1);
    localparam logic [DWL_W-1:0] DWELL_MAX = DWL_W'(DWELL_TICKS);
    localparam logic [IDX_W-1:0] RR_INIT   = IDX_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t             state_r, state_s;
    logic [PRE_W-1:0]   presc_r, presc_s;
    logic               tick_r, tick_s;
    logic [DWL_W-1:0]   dwell_r, dwell_s;
    // In HOLD the round-robin pointer is also the index of the current owner.
    logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_s;
    logic [NUM_REQ-1:0] grant_r, grant_s;
    logic               busy_r, busy_s;
    logic [7:0]         leds_r, leds_s;
    logic               pick_valid_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic               others_s;
    logic [7:0]         pat_s [NUM_REQ];

    // First asserted request searching upward from ptr+1 with wrap; ptr itself is seen last.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req_v,
                                               input logic [IDX_W-1:0]   ptr);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] k;
        res = {(IDX_W+1){1'b0}};
        for (int i = NUM_REQ; i >= 1; i--) begin
            k = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (req_v[k]) begin
                res = {1'b1, k};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [NUM_REQ-1:0] one_hot(input logic [IDX_W-1:0] idx);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_pat
        assign pat_s[g] = bus.pattern_in[8*g +: 8];
    end

    // Next-state and output computation for prescaler and arbitration FSM.
    always_comb begin
        state_s  = state_r;
        dwell_s  = dwell_r;
        rr_ptr_s = rr_ptr_r;
        grant_s  = grant_r;
        leds_s   = leds_r;

        if (presc_r == PRE_LAST) begin
            presc_s = {PRE_W{1'b0}};
        end else begin
            presc_s = presc_r + PRE_W'(1);
        end
        tick_s = (presc_s == PRE_LAST);

        {pick_valid_s, pick_idx_s} = rr_pick(bus.req, rr_ptr_r);
        others_s = |(bus.req & ~grant_r);

        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_s  = ST_HOLD;
                    grant_s  = one_hot(pick_idx_s);
                    rr_ptr_s = pick_idx_s;
                    dwell_s  = {DWL_W{1'b0}};
                    leds_s   = pat_s[pick_idx_s];
                end else if (tick_r) begin
                    leds_s = {leds_r[6:0], leds_r[7]};
                end else begin
                    leds_s = leds_r;
                end
            end
            ST_HOLD: begin
                // An owner drop takes priority over dwell expiry.
                if (!bus.req[rr_ptr_r]) begin
                    state_s = ST_IDLE;
                    grant_s = {NUM_REQ{1'b0}};
                    dwell_s = {DWL_W{1'b0}};
                    leds_s  = IDLE_PATTERN;
                end else if ((dwell_r == DWELL_MAX) && others_s) begin
                    grant_s  = one_hot(pick_idx_s);
                    rr_ptr_s = pick_idx_s;
                    dwell_s  = {DWL_W{1'b0}};
                    leds_s   = pat_s[pick_idx_s];
                end else begin
                    leds_s = pat_s[rr_ptr_r];
                    if (tick_r && (dwell_r != DWELL_MAX)) begin
                        dwell_s = dwell_r + DWL_W'(1);
                    end else begin
                        dwell_s = dwell_r;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = {NUM_REQ{1'b0}};
                dwell_s = {DWL_W{1'b0}};
                leds_s  = IDLE_PATTERN;
            end
        endcase

        busy_s = |grant_s;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            presc_r  <= {PRE_W{1'b0}};
            tick_r   <= 1'b0;
            dwell_r  <= {DWL_W{1'b0}};
            rr_ptr_r <= RR_INIT;
            grant_r  <= {NUM_REQ{1'b0}};
            busy_r   <= 1'b0;
            leds_r   <= IDLE_PATTERN;
        end else begin
            state_r  <= state_s;
            presc_r  <= presc_s;
            tick_r   <= tick_s;
            dwell_r  <= dwell_s;
            rr_ptr_r <= rr_ptr_s;
            grant_r  <= grant_s;
            busy_r   <= busy_s;
            leds_r   <= leds_s;
        end
    end

    assign bus.grant = grant_r;
    assign bus.busy  = busy_r;
    assign tick      = tick_r;
    assign leds      = leds_r;
endmodule

// File: tb/tb_led_display_arbiter.sv
// Bench for led_display_arbiter: hand-derived vector table, directed corner
// sequences and random traffic, all checked against a queued reference model.
module tb_led_display_arbiter;
    localparam int NR = 4;
    localparam int TP = 4;
    localparam int DW = 2;

    logic       clk_50mhz;
    logic       reset;
    logic       tick;
    logic [7:0] leds;

    led_display_arbiter_if #(.NUM_REQ(NR)) bus ();

    led_display_arbiter #(
        .NUM_REQ     (NR),
        .TICK_PERIOD (TP),
        .DWELL_TICKS (DW),
        .IDLE_PATTERN(8'h01)
    ) dut (
        .clk_50mhz(clk_50mhz),
        .reset    (reset),
        .bus      (bus),
        .tick     (tick),
        .leds     (leds)
    );

    initial clk_50mhz = 1'b0;
    always #5 clk_50mhz = ~clk_50mhz;

    typedef struct {
        logic [3:0] grant;
        logic       busy;
        logic [7:0] leds;
        logic       tick;
    } exp_t;

    typedef struct {
        bit         rst;
        logic [3:0] req;
        logic [7:0] p0;
        logic [3:0] exp_grant;
        logic [7:0] exp_leds;
        logic       exp_tick;
    } vec_t;

    exp_t        exp_q [$];
    logic [31:0] pats;
    int          total;
    int          bad;

    // reference model state
    bit          m_hold;
    int          m_ptr;
    int          m_dwell;
    int          m_presc;
    bit          m_tick;
    logic [7:0]  m_leds;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst_v, input logic [3:0] req_v);
        int  win;
        bit  cur_tick;
        exp_t e;
        if (rst_v) begin
            m_hold = 1'b0; m_ptr = NR - 1; m_dwell = 0;
            m_presc = 0; m_tick = 1'b0; m_leds = 8'h01;
        end else begin
            cur_tick = m_tick;
            win = -1;
            for (int off = 1; off <= NR; off++) begin
                if (win < 0 && req_v[(m_ptr + off) % NR]) win = (m_ptr + off) % NR;
            end
            m_presc = (m_presc + 1) % TP;
            m_tick  = (m_presc == TP - 1);
            if (!m_hold) begin
                if (win >= 0) begin
                    m_hold = 1'b1; m_ptr = win; m_dwell = 0; m_leds = pats[8*win +: 8];
                end else if (cur_tick) begin
                    m_leds = {m_leds[6:0], m_leds[7]};
                end
            end else if (!req_v[m_ptr]) begin
                m_hold = 1'b0; m_dwell = 0; m_leds = 8'h01;
            end else if (m_dwell == DW && (req_v & ~(4'b0001 << m_ptr)) != 4'b0000) begin
                m_ptr = win; m_dwell = 0; m_leds = pats[8*win +: 8];
            end else begin
                m_leds = pats[8*m_ptr +: 8];
                if (cur_tick && m_dwell < DW) m_dwell++;
            end
        end
        e.grant = m_hold ? (4'b0001 << m_ptr) : 4'b0000;
        e.busy  = m_hold;
        e.leds  = m_leds;
        e.tick  = m_tick;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of stimulus, queue the expectation, then compare after the edge.
    task automatic step(input bit rst_v, input logic [3:0] req_v);
        exp_t e;
        reset          = rst_v;
        bus.req        = req_v;
        bus.pattern_in = pats;
        model_step(rst_v, req_v);
        @(posedge clk_50mhz);
        #1;
        e = exp_q.pop_front();
        chk("grant", {28'd0, bus.grant}, {28'd0, e.grant});
        chk("busy",  {31'd0, bus.busy},  {31'd0, e.busy});
        chk("leds",  {24'd0, leds},      {24'd0, e.leds});
        chk("tick",  {31'd0, tick},      {31'd0, e.tick});
    endtask

    vec_t vecs [16];
    logic [3:0] seen [$];
    logic [3:0] last_g;
    logic [3:0] rq;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.req = 4'b0000;
        pats = {8'h96, 8'hC3, 8'h5A, 8'hA5};
        bus.pattern_in = pats;

        // rst, req, p0, grant, leds, tick  (row 0 = reset cycle, prescaler 0)
        vecs[0]  = '{1'b1, 4'b0000, 8'hA5, 4'b0000, 8'h01, 1'b0};
        vecs[1]  = '{1'b0, 4'b0000, 8'hA5, 4'b0000, 8'h01, 1'b0};
        vecs[2]  = '{1'b0, 4'b0000, 8'hA5, 4'b0000, 8'h01, 1'b0};
        vecs[3]  = '{1'b0, 4'b0000, 8'hA5, 4'b0000, 8'h01, 1'b1};
        vecs[4]  = '{1'b0, 4'b0000, 8'hA5, 4'b0000, 8'h02, 1'b0};
        vecs[5]  = '{1'b0, 4'b0000, 8'hA5, 4'b0000, 8'h02, 1'b0};
        vecs[6]  = '{1'b0, 4'b0000, 8'hA5, 4'b0000, 8'h02, 1'b0};
        vecs[7]  = '{1'b0, 4'b0000, 8'hA5, 4'b0000, 8'h02, 1'b1};
        vecs[8]  = '{1'b0, 4'b0000, 8'hA5, 4'b0000, 8'h04, 1'b0};
        vecs[9]  = '{1'b0, 4'b0000, 8'hA5, 4'b0000, 8'h04, 1'b0};
        vecs[10] = '{1'b0, 4'b0000, 8'hA5, 4'b0000, 8'h04, 1'b0};
        vecs[11] = '{1'b0, 4'b0000, 8'hA5, 4'b0000, 8'h04, 1'b1};
        vecs[12] = '{1'b0, 4'b0000, 8'hA5, 4'b0000, 8'h08, 1'b0};
        vecs[13] = '{1'b0, 4'b0001, 8'hA5, 4'b0001, 8'hA5, 1'b0};
        vecs[14] = '{1'b0, 4'b0001, 8'h3C, 4'b0001, 8'h3C, 1'b0};
        vecs[15] = '{1'b0, 4'b0001, 8'h3C, 4'b0001, 8'h3C, 1'b1};

        for (int i = 0; i < 16; i++) begin
            pats[7:0] = vecs[i].p0;
            step(vecs[i].rst, vecs[i].req);
            chk("tbl_grant", {28'd0, bus.grant}, {28'd0, vecs[i].exp_grant});
            chk("tbl_leds",  {24'd0, leds},      {24'd0, vecs[i].exp_leds});
            chk("tbl_tick",  {31'd0, tick},      {31'd0, vecs[i].exp_tick});
        end

        // Two requesters alternate after the dwell with no idle gap.
        step(1'b1, 4'b0000);
        last_g = 4'b0000;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 4'b0101);
            chk("rr_no_gap", {31'd0, (bus.grant != 4'b0000)}, 32'd1);
            if (bus.grant != last_g) seen.push_back(bus.grant);
            last_g = bus.grant;
        end
        chk("rr_changes", (seen.size() >= 3) ? 32'd1 : 32'd0, 32'd1);
        if (seen.size() >= 3) begin
            chk("rr_first",  {28'd0, seen[0]}, 32'h1);
            chk("rr_second", {28'd0, seen[1]}, 32'h4);
            chk("rr_third",  {28'd0, seen[2]}, 32'h1);
        end

        // Owner drops at dwell 1 while another requester rises.
        step(1'b1, 4'b0000);
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0010);
        step(1'b0, 4'b1000);
        chk("drop_grant", {28'd0, bus.grant}, 32'h0);
        chk("drop_leds",  {24'd0, leds},      32'h01);
        step(1'b0, 4'b1000);
        chk("after_drop_grant", {28'd0, bus.grant}, 32'h8);

        // Reset in the middle of a hold.
        for (int i = 0; i < 5; i++) step(1'b0, 4'b1111);
        step(1'b1, 4'b1111);
        chk("midrst_grant", {28'd0, bus.grant}, 32'h0);
        chk("midrst_leds",  {24'd0, leds},      32'h01);
        step(1'b0, 4'b1111);
        chk("postrst_grant", {28'd0, bus.grant}, 32'h1);

        // Lone requester keeps the grant through saturation, then yields at once.
        step(1'b1, 4'b0000);
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 4'b0100);
            chk("lone_grant", {28'd0, bus.grant}, 32'h4);
        end
        step(1'b0, 4'b0110);
        chk("sat_rotate", {28'd0, bus.grant}, 32'h2);

        // Random traffic against the model.
        step(1'b1, 4'b0000);
        rq = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) rq = 4'($urandom_range(0, 15));
            pats = $urandom;
            step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, rq);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
